// File: rtl/systolic_pkg.sv
// Shared constants, control-word field positions and the frame type for the
// systolic tile feeder.
package systolic_pkg;

  localparam int NIB_W   = 4;
  localparam int BEATS   = 16;
  localparam int FRAME_W = NIB_W * BEATS;
  localparam int CTRL_W  = 16;
  localparam int BEAT_W  = $clog2(BEATS);

  localparam int CTRL_ADDR_HI  = 15;
  localparam int CTRL_ADDR_LO  = 8;
  localparam int CTRL_SHIFT_IN = 5;

  localparam logic [7:0] ADDR_STATE = 8'h01;
  localparam logic [7:0] ADDR_A     = 8'h02;
  localparam logic [7:0] ADDR_B     = 8'h04;
  localparam logic [7:0] ADDR_C0    = 8'h08;
  localparam logic [7:0] ADDR_C1    = 8'h09;
  localparam logic [7:0] ADDR_C2    = 8'h0A;
  localparam logic [7:0] ADDR_C3    = 8'h0B;
  localparam logic [7:0] ADDR_C4    = 8'h0C;
  localparam logic [7:0] ADDR_C5    = 8'h0D;
  localparam logic [7:0] ADDR_C6    = 8'h0E;
  localparam logic [7:0] ADDR_C7    = 8'h0F;

  typedef struct packed {
    logic [FRAME_W-1:0] data;
    logic [CTRL_W-1:0]  ctrl;
  } frame_t;

  localparam frame_t IDLE_FRAME = {(FRAME_W + CTRL_W){1'b0}};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/systolic_frame_shifter.sv
// Frame-in-flight shift register with the free-running beat counter; a new
// frame is taken from i_next on every beat-15 edge.
module systolic_frame_shifter
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  frame_t            i_next,
  input  logic              i_next_nonidle,
  output logic [NIB_W-1:0]  o_nib,
  output logic              o_ctrl,
  output logic [BEAT_W-1:0] o_beat,
  output logic              o_sof,
  output logic              o_boundary,
  output logic              o_nonidle
);

  frame_t              r_cur;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_sof;
  logic                r_nonidle;
  logic                w_boundary;

  assign w_boundary = (r_beat == BEAT_W'(BEATS - 1));

  // Beat counter, shift register and frame-start tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur     <= IDLE_FRAME;
      r_beat    <= {BEAT_W{1'b0}};
      r_sof     <= 1'b1;
      r_nonidle <= 1'b0;
    end else if (w_boundary) begin
      r_cur     <= i_next;
      r_beat    <= {BEAT_W{1'b0}};
      r_sof     <= 1'b1;
      r_nonidle <= i_next_nonidle;
    end else begin
      r_cur.data <= {r_cur.data[FRAME_W-NIB_W-1:0], {NIB_W{1'b0}}};
      r_cur.ctrl <= {r_cur.ctrl[CTRL_W-2:0], 1'b0};
      r_beat     <= r_beat + BEAT_W'(1);
      r_sof      <= 1'b0;
      r_nonidle  <= r_nonidle;
    end
  end

  assign o_nib      = r_cur.data[FRAME_W-1 -: NIB_W];
  assign o_ctrl     = r_cur.ctrl[CTRL_W-1];
  assign o_beat     = r_beat;
  assign o_sof      = r_sof;
  assign o_boundary = w_boundary;
  assign o_nonidle  = r_nonidle;

endmodule

// File: rtl/systolic_frame_tx.sv
// Host-to-tile frame serialiser: one-entry pending slot, valid/ready handshake
// and idle-frame insertion. Optional statistics: SYSTOLIC_FRAME_TX_STATS_EN.
module systolic_frame_tx
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FRAME_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic [NIB_W-1:0]    out_nib,
  output logic                out_ctrl,
  output logic [BEAT_W-1:0]   out_beat,
  output logic                out_sof,
  output logic                busy
`ifdef SYSTOLIC_FRAME_TX_STATS_EN
  ,
  output logic [15:0]         stat_frames,
  output logic [15:0]         stat_idle
`endif
);

  frame_t r_pend;
  logic   r_pend_valid;
  frame_t w_in_frame;
  frame_t w_next;
  logic   w_next_nonidle;
  logic   w_boundary;
  logic   w_nonidle;
  logic   w_accept;

  assign w_in_frame = '{data: in_data, ctrl: in_ctrl};
  assign in_ready   = !r_pend_valid || w_boundary;
  assign w_accept   = in_valid && in_ready;
  assign busy       = r_pend_valid || w_nonidle;

  // Next frame at the boundary: pending word first, then bypass, else idle.
  always_comb begin
    w_next         = IDLE_FRAME;
    w_next_nonidle = 1'b0;
    if (r_pend_valid) begin
      w_next         = r_pend;
      w_next_nonidle = 1'b1;
    end else if (w_accept) begin
      w_next         = w_in_frame;
      w_next_nonidle = 1'b1;
    end else begin
      w_next         = IDLE_FRAME;
      w_next_nonidle = 1'b0;
    end
  end

  // Pending slot: a word bypassed straight into the shifter never lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= IDLE_FRAME;
      r_pend_valid <= 1'b0;
    end else if (w_accept && (!w_boundary || r_pend_valid)) begin
      r_pend       <= w_in_frame;
      r_pend_valid <= 1'b1;
    end else if (w_boundary) begin
      r_pend       <= r_pend;
      r_pend_valid <= 1'b0;
    end else begin
      r_pend       <= r_pend;
      r_pend_valid <= r_pend_valid;
    end
  end

  systolic_frame_shifter u_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_next        (w_next),
    .i_next_nonidle(w_next_nonidle),
    .o_nib         (out_nib),
    .o_ctrl        (out_ctrl),
    .o_beat        (out_beat),
    .o_sof         (out_sof),
    .o_boundary    (w_boundary),
    .o_nonidle     (w_nonidle)
  );

`ifdef SYSTOLIC_FRAME_TX_STATS_EN
  logic [15:0] r_frames;
  logic [15:0] r_idle;

  // Saturating per-boundary counts of word frames and idle frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames <= 16'h0000;
      r_idle   <= 16'h0000;
    end else if (w_boundary && w_next_nonidle) begin
      r_frames <= sat_inc16(r_frames);
      r_idle   <= r_idle;
    end else if (w_boundary) begin
      r_frames <= r_frames;
      r_idle   <= sat_inc16(r_idle);
    end else begin
      r_frames <= r_frames;
      r_idle   <= r_idle;
    end
  end

  assign stat_frames = r_frames;
  assign stat_idle   = r_idle;
`endif

endmodule
